// File: rtl/tetris_board_renderer.sv
// tetris_board_renderer: renders a double-buffered Tetris board from VGA pixel counters with a fixed 2-clock latency
// Ports: clk/rst (async, active-high); pix_x/pix_y/blank_n_in/hs_in/vs_in from the timing generator;
// wr_valid/wr_ready/wr_col/wr_row/wr_color write a back-buffer cell; commit_req/commit_ack publish the back buffer
// at vblank start; vga_HS/vga_VS/vga_BLANK_N/R/G/B are the re-timed outputs.
module tetris_board_renderer #(
    parameter int BOARD_COLS = 10,
    parameter int BOARD_ROWS = 20,
    parameter int CELL_LOG2  = 4,
    parameter int ORIGIN_X   = 240,
    parameter int ORIGIN_Y   = 80,
    parameter int V_ACTIVE   = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       blank_n_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [2:0] wr_color,
    input  logic       commit_req,
    output logic       commit_ack,
    output logic       vga_HS,
    output logic       vga_VS,
    output logic       vga_BLANK_N,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B
);
    localparam int CELLS = BOARD_COLS * BOARD_ROWS;
    localparam int IW = $clog2(CELLS);
    typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;
    state_t state;
    logic disp_sel;
    logic [IW-1:0] cnt;
    logic [2:0] bank [2][CELLS];
    logic [10:0] rx, ry;
    logic in_board, wr_in_range;
    logic [IW-1:0] pix_idx, wr_idx;
    logic [2:0] s1_color;
    logic s1_in, s1_edge, s1_bn, s1_hs, s1_vs;
    logic [23:0] pal, rgb;
    // Pixels left of / above the origin wrap to large values, so one unsigned compare per axis suffices.
    always_comb begin
        rx = {1'b0, pix_x} - 11'(ORIGIN_X);
        ry = {1'b0, pix_y} - 11'(ORIGIN_Y);
        in_board = rx < 11'(BOARD_COLS << CELL_LOG2) && ry < 11'(BOARD_ROWS << CELL_LOG2);
        pix_idx = in_board ? IW'(ry >> CELL_LOG2) * IW'(BOARD_COLS) + IW'(rx >> CELL_LOG2) : '0;
        wr_in_range = int'(wr_col) < BOARD_COLS && int'(wr_row) < BOARD_ROWS;
        wr_idx = IW'(wr_row) * IW'(BOARD_COLS) + IW'(wr_col);
    end
    always_comb begin
        case (s1_color)
            3'd1:    pal = 24'h00FFFF;
            3'd2:    pal = 24'hFFFF00;
            3'd3:    pal = 24'hA000F0;
            3'd4:    pal = 24'h00F000;
            3'd5:    pal = 24'hF00000;
            3'd6:    pal = 24'h0000F0;
            3'd7:    pal = 24'hF0A000;
            default: pal = s1_edge ? 24'h202020 : 24'h000000;
        endcase
        rgb = s1_bn && s1_in ? pal : 24'h0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_color <= '0;
            s1_in <= 1'b0;
            s1_edge <= 1'b0;
            s1_bn <= 1'b0;
            s1_hs <= 1'b1;
            s1_vs <= 1'b1;
            {R, G, B} <= '0;
            vga_HS <= 1'b1;
            vga_VS <= 1'b1;
            vga_BLANK_N <= 1'b0;
        end else begin
            s1_color <= bank[disp_sel][pix_idx];
            s1_in <= in_board;
            s1_edge <= pix_x[CELL_LOG2-1:0] == '0 || pix_y[CELL_LOG2-1:0] == '0;
            s1_bn <= blank_n_in;
            s1_hs <= hs_in;
            s1_vs <= vs_in;
            {R, G, B} <= rgb;
            vga_HS <= s1_hs;
            vga_VS <= s1_vs;
            vga_BLANK_N <= s1_bn;
        end
    end
    // After the swap, the copy refreshes the new back bank from the new front so edits start from what is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            disp_sel <= 1'b0;
            cnt <= '0;
            wr_ready <= 1'b1;
            commit_ack <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                bank[0][i] <= '0;
                bank[1][i] <= '0;
            end
        end else begin
            commit_ack <= 1'b0;
            if (wr_valid && wr_ready && wr_in_range)
                bank[~disp_sel][wr_idx] <= wr_color;
            case (state)
                IDLE:
                    if (commit_req) begin
                        state <= PENDING;
                        wr_ready <= 1'b0;
                    end
                PENDING:
                    if (pix_y == 10'(V_ACTIVE) && pix_x == '0) begin
                        disp_sel <= ~disp_sel;
                        cnt <= '0;
                        state <= COPY;
                    end
                COPY: begin
                    bank[~disp_sel][cnt] <= bank[disp_sel][cnt];
                    if (cnt == IW'(CELLS - 1)) begin
                        state <= IDLE;
                        wr_ready <= 1'b1;
                        commit_ack <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
